issue_queue: RTL and testbench

//  Dual-port circular instruction queue between decode and the issue/EX pipeline register.
//  - Accepts up to two decoded instruction packets per cycle from decode.
//  - Presents up to two packets per cycle as issue slot 1 (A) and issue slot 2 (B) to the EX register stage.
//  - Pairs the two oldest entries only when they have no intra-pair RAW hazard and no dual memory access.
//  - Drains on a branch flush and holds on a D-cache stall.

---
 rtl/issue_queue.sv | 181 ++++++++++++++++++
 tb/tb_issue_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : issue_queue
//  Description : Dual-port circular instruction queue sitting between decode
//                and the issue/EX pipeline register. Accepts up to two decoded
//                packets per cycle and offers the two oldest entries as issue
//                slots A and B. Slot B is only offered when the pair has no
//                RAW hazard and is not a dual memory access. Drains on a
//                branch flush and holds on a D-cache stall.
//  Ports       : clk, rstn (sync, active low)
//                in_valid1/2, in_pkt1/2, in_rd1/2, in_we1/2, in_rs1_1/2,
//                in_rs2_1/2, in_mem1/2  - decode side, packet 1 is older
//                in_ready               - room for two packets this cycle
//                flush_BR, stall_DCache - pipeline control
//                o_valid1/o_pkt1        - issue slot A (oldest entry)
//                o_valid2/o_pkt2        - issue slot B (second-oldest entry)
//                o_count                - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int PKT_W = 160
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid1,
    input  logic                     in_valid2,
    input  logic [PKT_W-1:0]         in_pkt1,
    input  logic [PKT_W-1:0]         in_pkt2,
    input  logic [4:0]               in_rd1,
    input  logic [4:0]               in_rd2,
    input  logic                     in_we1,
    input  logic                     in_we2,
    input  logic [4:0]               in_rs1_1,
    input  logic [4:0]               in_rs1_2,
    input  logic [4:0]               in_rs2_1,
    input  logic [4:0]               in_rs2_2,
    input  logic                     in_mem1,
    input  logic                     in_mem2,
    output logic                     in_ready,
    input  logic                     flush_BR,
    input  logic                     stall_DCache,
    output logic                     o_valid1,
    output logic [PKT_W-1:0]         o_pkt1,
    output logic                     o_valid2,
    output logic [PKT_W-1:0]         o_pkt2,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_TWO  = c_CW'(2);
    localparam logic [c_CW-1:0] c_FULL_M2  = c_CW'(DEPTH - 2);

    typedef struct packed {
        logic [PKT_W-1:0] pkt;
        logic [4:0]       rd;
        logic             we;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic             mem;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [c_AW-1:0] head_q, head_d;
    logic [c_AW-1:0] tail_q, tail_d;
    logic [c_CW-1:0] count_q, count_d;

    logic [c_AW-1:0] w_head1;
    logic [c_AW-1:0] w_tail1;
    entry_t          w_ent_a;
    entry_t          w_ent_b;
    entry_t          w_new1;
    entry_t          w_new2;
    logic            w_hazard;
    logic            w_dual_mem;
    logic            w_push1;
    logic            w_push2;
    logic            w_pop1;
    logic            w_pop2;
    logic [1:0]      w_push_n;
    logic [1:0]      w_pop_n;

    // ------------------------------------------------------------------
    // Issue side: purely combinational from head
    // ------------------------------------------------------------------
    always_comb begin
        w_head1 = head_q + c_PTR_ONE;
        w_ent_a = ent_q[head_q];
        w_ent_b = ent_q[w_head1];

        // Slot B consumes a register that slot A writes in the same cycle;
        // x0 is hardwired so a write to it never creates a dependency.
        w_hazard   = w_ent_a.we && (w_ent_a.rd != 5'd0) &&
                     ((w_ent_a.rd == w_ent_b.rs1) || (w_ent_a.rd == w_ent_b.rs2));
        w_dual_mem = w_ent_a.mem && w_ent_b.mem;

        o_valid1 = (count_q != '0);
        o_valid2 = (count_q >= c_CNT_TWO) && !w_hazard && !w_dual_mem;
        o_pkt1   = w_ent_a.pkt;
        o_pkt2   = w_ent_b.pkt;
        o_count  = count_q;
    end

    // ------------------------------------------------------------------
    // Push / pop bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        // Readiness looks at the current occupancy only, so a full queue
        // that is draining this cycle still refuses new packets.
        in_ready = (count_q <= c_FULL_M2);
        w_tail1  = tail_q + c_PTR_ONE;

        w_push1  = in_ready && in_valid1;
        w_push2  = w_push1 && in_valid2;
        w_pop1   = !stall_DCache && o_valid1;
        w_pop2   = !stall_DCache && o_valid2;

        w_push_n = {1'b0, w_push1} + {1'b0, w_push2};
        w_pop_n  = {1'b0, w_pop1} + {1'b0, w_pop2};

        head_d   = head_q + c_AW'(w_pop_n);
        tail_d   = tail_q + c_AW'(w_push_n);
        count_d  = count_q + c_CW'(w_push_n) - c_CW'(w_pop_n);

        w_new1.pkt = in_pkt1;
        w_new1.rd  = in_rd1;
        w_new1.we  = in_we1;
        w_new1.rs1 = in_rs1_1;
        w_new1.rs2 = in_rs2_1;
        w_new1.mem = in_mem1;

        w_new2.pkt = in_pkt2;
        w_new2.rd  = in_rd2;
        w_new2.we  = in_we2;
        w_new2.rs1 = in_rs1_2;
        w_new2.rs2 = in_rs2_2;
        w_new2.mem = in_mem2;

        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (w_push1) begin
            ent_d[tail_q] = w_new1;
        end
        if (w_push2) begin
            ent_d[w_tail1] = w_new2;
        end
    end

    // ------------------------------------------------------------------
    // State registers: reset beats flush beats normal update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_BR) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; stale contents are never marked valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_queue
//  Description : Directed self-checking bench for issue_queue (DEPTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int PKT_W = 160;

    logic             clk;
    logic             rstn;
    logic             in_valid1, in_valid2;
    logic [PKT_W-1:0] in_pkt1, in_pkt2;
    logic [4:0]       in_rd1, in_rd2;
    logic             in_we1, in_we2;
    logic [4:0]       in_rs1_1, in_rs1_2, in_rs2_1, in_rs2_2;
    logic             in_mem1, in_mem2;
    logic             in_ready;
    logic             flush_BR, stall_DCache;
    logic             o_valid1, o_valid2;
    logic [PKT_W-1:0] o_pkt1, o_pkt2;
    logic [3:0]       o_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_pc [30];

    issue_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid1    (in_valid1),
        .in_valid2    (in_valid2),
        .in_pkt1      (in_pkt1),
        .in_pkt2      (in_pkt2),
        .in_rd1       (in_rd1),
        .in_rd2       (in_rd2),
        .in_we1       (in_we1),
        .in_we2       (in_we2),
        .in_rs1_1     (in_rs1_1),
        .in_rs1_2     (in_rs1_2),
        .in_rs2_1     (in_rs2_1),
        .in_rs2_2     (in_rs2_2),
        .in_mem1      (in_mem1),
        .in_mem2      (in_mem2),
        .in_ready     (in_ready),
        .flush_BR     (flush_BR),
        .stall_DCache (stall_DCache),
        .o_valid1     (o_valid1),
        .o_pkt1       (o_pkt1),
        .o_valid2     (o_valid2),
        .o_pkt2       (o_pkt2),
        .o_count      (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] pk(input logic [31:0] pc);
        return {pc, 96'h0, ~pc};
    endfunction

    task automatic chk(input string tag, input logic [PKT_W-1:0] obs,
                       input logic [PKT_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v1, input logic v2,
                       input logic [31:0] pc1, input logic [4:0] rd1, input logic we1,
                       input logic [4:0] a1, input logic [4:0] b1, input logic m1,
                       input logic [31:0] pc2, input logic [4:0] rd2, input logic we2,
                       input logic [4:0] a2, input logic [4:0] b2, input logic m2);
        in_valid1 = v1;  in_valid2 = v2;
        in_pkt1 = pk(pc1); in_rd1 = rd1; in_we1 = we1;
        in_rs1_1 = a1; in_rs2_1 = b1; in_mem1 = m1;
        in_pkt2 = pk(pc2); in_rd2 = rd2; in_we2 = we2;
        in_rs1_2 = a2; in_rs2_2 = b2; in_mem2 = m2;
    endtask

    // Independent, non-memory pair of packets
    task automatic put_plain(input logic [31:0] pc);
        put(1'b1, 1'b1, pc, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0,
            pc + 32'd4, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic clr();
        put(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0,
            32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; flush_BR = 1'b0; stall_DCache = 1'b0;
        clr();

        // ---------------- reset with a push attempt held ----------------
        put_plain(32'h0F00);
        step(); step();
        chk("rst_count", o_count, 0);
        chk("rst_valid1", o_valid1, 0);
        chk("rst_ready", in_ready, 1);
        rstn = 1'b1; clr();
        step();
        chk("rel_count", o_count, 0);
        chk("rel_valid1", o_valid1, 0);
        chk("rel_valid2", o_valid2, 0);

        // ---------------- pair issue ----------------
        put(1'b1, 1'b1, 32'h1000, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0,
            32'h1004, 5'd0, 1'b0, 5'd6, 5'd7, 1'b0);
        step(); clr();
        chk("pair_count", o_count, 2);
        chk("pair_v1", o_valid1, 1);
        chk("pair_v2", o_valid2, 1);
        chk("pair_pkt1", o_pkt1, pk(32'h1000));
        chk("pair_pkt2", o_pkt2, pk(32'h1004));
        step();
        chk("pair_drain", o_count, 0);
        chk("pair_v1_off", o_valid1, 0);

        // ---------------- RAW split ----------------
        put(1'b1, 1'b1, 32'h2000, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0,
            32'h2004, 5'd0, 1'b0, 5'd0, 5'd5, 1'b0);
        step(); clr();
        chk("raw_count", o_count, 2);
        chk("raw_v1", o_valid1, 1);
        chk("raw_v2", o_valid2, 0);
        chk("raw_pkt1", o_pkt1, pk(32'h2000));
        step();
        chk("raw_count1", o_count, 1);
        chk("raw_b_in_a", o_pkt1, pk(32'h2004));
        chk("raw_b_v1", o_valid1, 1);
        step();
        chk("raw_drain", o_count, 0);

        // rd=0 write never creates a dependency
        put(1'b1, 1'b1, 32'h2100, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0,
            32'h2104, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        step(); clr();
        chk("rd0_v2", o_valid2, 1);
        chk("rd0_pkt2", o_pkt2, pk(32'h2104));
        step();
        chk("rd0_drain", o_count, 0);

        // ---------------- dual memory access ----------------
        put(1'b1, 1'b1, 32'h3000, 5'd1, 1'b1, 5'd0, 5'd0, 1'b1,
            32'h3004, 5'd2, 1'b1, 5'd0, 5'd0, 1'b1);
        step(); clr();
        chk("mem_count", o_count, 2);
        chk("mem_v2", o_valid2, 0);
        chk("mem_pkt1", o_pkt1, pk(32'h3000));
        step();
        chk("mem_count1", o_count, 1);
        chk("mem_pkt1b", o_pkt1, pk(32'h3004));
        step();
        chk("mem_drain", o_count, 0);

        // ---------------- valid2 alone ignored, then single push ----------------
        put(1'b0, 1'b1, 32'h3700, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0,
            32'h3704, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        step(); clr();
        chk("v2only_count", o_count, 0);
        chk("v2only_v1", o_valid1, 0);
        put(1'b1, 1'b0, 32'h3800, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0,
            32'h3804, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        step(); clr();
        chk("single_count", o_count, 1);
        chk("single_v2", o_valid2, 0);
        chk("single_pkt1", o_pkt1, pk(32'h3800));
        step();
        chk("single_drain", o_count, 0);

        // ---------------- fill under stall, overflow drop, wrap ----------------
        stall_DCache = 1'b1;
        for (int k = 0; k < 4; k++) begin
            put_plain(32'h4000 + 32'(8 * k));
            step();
            chk("fill_count", o_count, 160'(2 * (k + 1)));
        end
        clr();
        chk("full_ready", in_ready, 0);
        chk("full_pkt1", o_pkt1, pk(32'h4000));
        put_plain(32'h5000);
        step(); clr();
        chk("drop_count", o_count, 8);
        chk("drop_pkt1", o_pkt1, pk(32'h4000));
        stall_DCache = 1'b0;
        chk("rel_v2", o_valid2, 1);
        chk("rel_pkt2", o_pkt2, pk(32'h4004));
        step();
        chk("rel_count", o_count, 6);

        for (int i = 0; i < 6; i++)  exp_pc[i] = 32'h4008 + 32'(4 * i);
        for (int i = 0; i < 24; i++) exp_pc[6 + i] = 32'h6000 + 32'(4 * i);

        for (int k = 0; k < 12; k++) begin
            put_plain(32'h6000 + 32'(8 * k));
            chk("wrap_ready", in_ready, 1);
            chk("wrap_v2", o_valid2, 1);
            chk("wrap_pkt1", o_pkt1, pk(exp_pc[2 * k]));
            chk("wrap_pkt2", o_pkt2, pk(exp_pc[2 * k + 1]));
            step();
            chk("wrap_count", o_count, 6);
        end
        clr();
        for (int j = 0; j < 3; j++) begin
            chk("tail_pkt1", o_pkt1, pk(exp_pc[24 + 2 * j]));
            chk("tail_pkt2", o_pkt2, pk(exp_pc[25 + 2 * j]));
            step();
            chk("tail_count", o_count, 160'(4 - 2 * j));
        end

        // ---------------- stall hold, then flush with push ----------------
        stall_DCache = 1'b1;
        put_plain(32'h7000); step();
        put_plain(32'h7008); step();
        clr();
        chk("stall_count0", o_count, 4);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("stall_count", o_count, 4);
            chk("stall_pkt1", o_pkt1, pk(32'h7000));
            chk("stall_pkt2", o_pkt2, pk(32'h7004));
            chk("stall_v2", o_valid2, 1);
        end
        flush_BR = 1'b1;
        put_plain(32'h7100);
        step();
        flush_BR = 1'b0; clr();
        chk("flush_count", o_count, 0);
        chk("flush_v1", o_valid1, 0);
        chk("flush_v2", o_valid2, 0);
        stall_DCache = 1'b0;

        // ---------------- reset in mid-operation ----------------
        put_plain(32'h7200);
        step(); clr();
        chk("mid_count", o_count, 2);
        chk("mid_pkt1", o_pkt1, pk(32'h7200));
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("midrst_count", o_count, 0);
        chk("midrst_v1", o_valid1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
